// File: rtl/cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmp_arbiter
// Purpose  : Round-robin sharing of one WIDTH-bit equality comparator between
//            two requesters. The granted operands are latched onto the
//            comparator inputs. The result R is sampled CMP_LAT edges later
//            and returned with a one-cycle done pulse.
// Ports    : CLK, Reset (async, active-high)
//            req0/op0/a0/b0, req1/op1/a1/b1  - requester inputs (op: 0=eq, 1=ne)
//            grant0/1, done0/1, res0/1, busy - requester-side status (registered)
//            cmp_A, cmp_B, cmp_eq, cmp_ne    - comparator drive (registered)
//            cmp_R                           - comparator result
// Revision : 1.0 - initial release
// ============================================================================
module cmp_arbiter #(
  parameter int WIDTH   = 16,
  parameter int CMP_LAT = 1     // legal range 1..15
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             grant0,
  output logic             grant1,
  output logic             done0,
  output logic             done1,
  output logic             res0,
  output logic             res1,
  output logic             busy,
  output logic [WIDTH-1:0] cmp_A,
  output logic [WIDTH-1:0] cmp_B,
  output logic             cmp_eq,
  output logic             cmp_ne,
  input  logic             cmp_R
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count value at which R has settled for CMP_LAT edges.
  localparam logic [3:0] C_CNT_LAST = 4'(CMP_LAT - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_rr_ptr;   // requester favoured when both request
  logic       r_sel;      // requester currently being served

  // Arbitration decision: requester 1 wins if it is the only one asking, or
  // if both ask and the pointer favours it. Feeds registers only.
  logic             w_pick1;
  logic             w_any;
  logic             w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  always_comb begin
    w_any   = req0 | req1;
    w_pick1 = req1 & (~req0 | r_rr_ptr);
    w_op    = w_pick1 ? op1 : op0;
    w_a     = w_pick1 ? a1  : a0;
    w_b     = w_pick1 ? b1  : b0;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_rr_ptr <= 1'b0;
      r_sel    <= 1'b0;
      grant0   <= 1'b0;
      grant1   <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      res0     <= 1'b0;
      res1     <= 1'b0;
      busy     <= 1'b0;
      cmp_A    <= '0;
      cmp_B    <= '0;
      cmp_eq   <= 1'b0;
      cmp_ne   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            // Operands are captured here; later input changes cannot
            // disturb the comparison in flight.
            r_sel   <= w_pick1;
            cmp_A   <= w_a;
            cmp_B   <= w_b;
            cmp_eq  <= ~w_op;
            cmp_ne  <= w_op;
            grant0  <= ~w_pick1;
            grant1  <= w_pick1;
            busy    <= 1'b1;
            r_cnt   <= 4'd0;
            r_state <= CMP;
          end else begin
            // cmp_A/cmp_B keep their last values while idle.
            cmp_eq <= 1'b0;
            cmp_ne <= 1'b0;
          end
        end

        CMP: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == C_CNT_LAST) begin
            if (r_sel) begin
              res1  <= cmp_R;
              done1 <= 1'b1;
            end else begin
              res0  <= cmp_R;
              done0 <= 1'b1;
            end
            cmp_eq   <= 1'b0;
            cmp_ne   <= 1'b0;
            r_rr_ptr <= ~r_sel;
            r_state  <= DONE;
          end
        end

        DONE: begin
          done0   <= 1'b0;
          done1   <= 1'b0;
          grant0  <= 1'b0;
          grant1  <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_arbiter
// Purpose  : Self-checking bench for cmp_arbiter. Two instances are built:
//            dut0 with CMP_LAT=1 and dut1 with CMP_LAT=3. Each instance has a
//            transaction-level timing model and a per-cycle compare process.
//            Directed stimulus adds literal checks that pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_arbiter;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  logic [1:0]  req0_v = '0, op0_v = '0, req1_v = '0, op1_v = '0;
  logic [15:0] a0_v [2];
  logic [15:0] b0_v [2];
  logic [15:0] a1_v [2];
  logic [15:0] b1_v [2];
  logic [15:0] cmpA_v [2];
  logic [15:0] cmpB_v [2];
  logic [1:0]  grant0_v, grant1_v, done0_v, done1_v, res0_v, res1_v, busy_v;
  logic [1:0]  eq_v, ne_v, R_v;

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;
  int  ncnt   = 0;    // negedge counter, used to time done pulses

  always @(negedge CLK) ncnt++;

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [dut%0d]: got %0h, expected %0h", name, inst, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 3;

    cmp_arbiter #(.WIDTH(16), .CMP_LAT(L)) u_dut (
      .CLK    (CLK),
      .Reset  (Reset),
      .req0   (req0_v[gi]),
      .op0    (op0_v[gi]),
      .a0     (a0_v[gi]),
      .b0     (b0_v[gi]),
      .req1   (req1_v[gi]),
      .op1    (op1_v[gi]),
      .a1     (a1_v[gi]),
      .b1     (b1_v[gi]),
      .grant0 (grant0_v[gi]),
      .grant1 (grant1_v[gi]),
      .done0  (done0_v[gi]),
      .done1  (done1_v[gi]),
      .res0   (res0_v[gi]),
      .res1   (res1_v[gi]),
      .busy   (busy_v[gi]),
      .cmp_A  (cmpA_v[gi]),
      .cmp_B  (cmpB_v[gi]),
      .cmp_eq (eq_v[gi]),
      .cmp_ne (ne_v[gi]),
      .cmp_R  (R_v[gi])
    );

    // Behavioural comparator: R follows the selected compare of A and B.
    assign R_v[gi] = eq_v[gi] ? (cmpA_v[gi] == cmpB_v[gi]) :
                     ne_v[gi] ? (cmpA_v[gi] != cmpB_v[gi]) : 1'b0;

    // Transaction model: each op is a start edge s. It owns the comparator
    // for edges s..s+L-1, holds grant through s+L (done edge), and the
    // arbiter next samples requests at edge s+L+2.
    int          cyc = 0, m_next = 0, m_s = 0, m_who = 0, m_ptr = 0;
    bit          m_have = 0, m_op = 0, m_rv = 0, m_res0 = 0, m_res1 = 0;
    logic [15:0] m_A = '0, m_B = '0;

    always @(posedge CLK or posedge Reset) begin
      if (Reset) begin
        cyc = 0; m_next = 0; m_s = 0; m_who = 0; m_ptr = 0;
        m_have = 0; m_op = 0; m_rv = 0; m_res0 = 0; m_res1 = 0;
        m_A = '0; m_B = '0;
      end else begin
        cyc++;
        if (cyc >= m_next && (req0_v[gi] || req1_v[gi])) begin
          if (req0_v[gi] && req1_v[gi]) m_who = m_ptr;
          else                          m_who = req1_v[gi] ? 1 : 0;
          m_A    = m_who ? a1_v[gi]  : a0_v[gi];
          m_B    = m_who ? b1_v[gi]  : b0_v[gi];
          m_op   = m_who ? op1_v[gi] : op0_v[gi];
          m_rv   = m_op ? (m_A != m_B) : (m_A == m_B);
          m_ptr  = 1 - m_who;
          m_s    = cyc;
          m_next = cyc + L + 2;
          m_have = 1;
        end
        if (m_have && cyc == m_s + L) begin
          if (m_who == 1) m_res1 = m_rv;
          else            m_res0 = m_rv;
        end
      end
    end

    always @(negedge CLK) begin : p_cmp
      int d;
      bit inop;
      if (chk_en) begin
        d    = cyc - m_s;
        inop = m_have && d <= L;
        chk("grant0", gi, grant0_v[gi], inop && m_who == 0);
        chk("grant1", gi, grant1_v[gi], inop && m_who == 1);
        chk("done0",  gi, done0_v[gi],  inop && d == L && m_who == 0);
        chk("done1",  gi, done1_v[gi],  inop && d == L && m_who == 1);
        chk("busy",   gi, busy_v[gi],   inop);
        chk("cmp_eq", gi, eq_v[gi],     m_have && d < L && !m_op);
        chk("cmp_ne", gi, ne_v[gi],     m_have && d < L && m_op);
        chk("cmp_A",  gi, cmpA_v[gi],   m_A);
        chk("cmp_B",  gi, cmpB_v[gi],   m_B);
        chk("res0",   gi, res0_v[gi],   m_res0);
        chk("res1",   gi, res1_v[gi],   m_res1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  // Wait for done on one port of one instance; n = negedges waited.
  task automatic wait_done(input int inst, input int port, input int maxc,
                           output int n);
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < maxc) begin
      @(negedge CLK);
      n++;
      seen = port ? done1_v[inst] : done0_v[inst];
    end
    chk("wait_done", inst, seen, 1);
    #1;
  endtask

  task automatic wait_any(input int inst, input int maxc,
                          output int who, output int t);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    who = -1;
    while (!seen && n < maxc) begin
      @(negedge CLK);
      n++;
      seen = done0_v[inst] | done1_v[inst];
    end
    chk("wait_any", inst, seen, 1);
    if (done1_v[inst]) who = 1;
    else if (done0_v[inst]) who = 0;
    t = ncnt;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    int n, who, t, tprev, nne, nd;
    for (int i = 0; i < 2; i++) begin
      a0_v[i] = '0; b0_v[i] = '0; a1_v[i] = '0; b1_v[i] = '0;
    end

    // ---- reset state ----
    @(posedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_busy", 0, busy_v[0], 0);
    chk("rst_res0", 0, res0_v[0], 0);
    chk("rst_cmpA", 0, cmpA_v[0], 16'h0000);
    #1;
    Reset = 1'b0;

    // ---- single equal compare on port 0 ----
    req0_v[0] = 1; op0_v[0] = 0; a0_v[0] = 16'h1234; b0_v[0] = 16'h1234;
    @(negedge CLK);
    chk("t1_grant0", 0, grant0_v[0], 1);
    chk("t1_eq",     0, eq_v[0],     1);
    chk("t1_cmpA",   0, cmpA_v[0],   16'h1234);
    chk("t1_done0",  0, done0_v[0],  0);
    @(negedge CLK);
    chk("t1_done0p", 0, done0_v[0],  1);
    chk("t1_res0",   0, res0_v[0],   1);
    #1 req0_v[0] = 0;
    @(negedge CLK);
    chk("t1_busy",   0, busy_v[0],   0);
    tick(1);

    // ---- not-equal compare on port 1 ----
    req1_v[0] = 1; op1_v[0] = 1; a1_v[0] = 16'h0005; b1_v[0] = 16'h0006;
    @(negedge CLK);
    chk("t2_ne", 0, ne_v[0], 1);
    chk("t2_eq", 0, eq_v[0], 0);
    @(negedge CLK);
    chk("t2_done1", 0, done1_v[0], 1);
    chk("t2_res1",  0, res1_v[0],  1);
    chk("t2_res0",  0, res0_v[0],  1);
    #1 req1_v[0] = 0;
    tick(2);

    // ---- both requesters held straight after reset: order 0,1,0,1 ----
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    req0_v[0] = 1; op0_v[0] = 0; a0_v[0] = 16'h0007; b0_v[0] = 16'h0007;
    req1_v[0] = 1; op1_v[0] = 0; a1_v[0] = 16'h0001; b1_v[0] = 16'h0002;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any(0, 10, who, t);
      chk("t3_order", 0, who, k % 2);
      if (k > 0) chk("t3_gap", 0, t - tprev, 3);
      tprev = t;
    end
    chk("t3_res0", 0, res0_v[0], 1);
    chk("t3_res1", 0, res1_v[0], 0);
    req0_v[0] = 0; req1_v[0] = 0;
    tick(3);

    // ---- operand change after grant has no effect ----
    req0_v[0] = 1; op0_v[0] = 0; a0_v[0] = 16'hFFFF; b0_v[0] = 16'hFFFF;
    @(negedge CLK);
    #1 a0_v[0] = 16'h0000;
    wait_done(0, 0, 10, n);
    chk("t4_cmpA", 0, cmpA_v[0], 16'hFFFF);
    chk("t4_res0", 0, res0_v[0], 1);
    req0_v[0] = 0;
    tick(2);

    // ---- reset during CMP, then a fresh op with req0 held ----
    req0_v[0] = 1; op0_v[0] = 1; a0_v[0] = 16'h0003; b0_v[0] = 16'h0004;
    @(negedge CLK);
    chk("t5_grant0", 0, grant0_v[0], 1);
    #1 Reset = 1'b1;
    #1;
    chk("t5_rst_grant0", 0, grant0_v[0], 0);
    chk("t5_rst_busy",   0, busy_v[0],   0);
    chk("t5_rst_res0",   0, res0_v[0],   0);
    chk("t5_rst_ne",     0, ne_v[0],     0);
    chk("t5_rst_cmpA",   0, cmpA_v[0],   16'h0000);
    tick(1);
    Reset = 1'b0;
    wait_done(0, 0, 10, n);
    chk("t5_latency", 0, n, 2);
    chk("t5_res0",    0, res0_v[0], 1);
    chk("t5_cmpA",    0, cmpA_v[0], 16'h0003);
    req0_v[0] = 0;
    tick(2);

    // ---- CMP_LAT=3 instance: cmp_ne width and done latency ----
    req0_v[1] = 1; op0_v[1] = 1; a0_v[1] = 16'h0000; b0_v[1] = 16'h0000;
    nne = 0;
    nd  = 0;
    for (int k = 1; k <= 10 && nd == 0; k++) begin
      @(negedge CLK);
      if (ne_v[1]) nne++;
      if (done0_v[1]) nd = k;
    end
    #1;
    chk("t6_ne_cycles", 1, nne, 3);
    chk("t6_done_edge", 1, nd - 1, 3);
    chk("t6_res0",      1, res0_v[1], 0);
    req0_v[1] = 0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares the single 16-bit comparator (inputs A, B, cmpeq, cmpne; output R) between two requesters, e.g. the branch unit (port 0) and the set-on-compare unit (port 1).
- Arbitrates round-robin, latches the granted operands, drives the comparator, waits a fixed settle time, samples R and returns the result with a one-cycle done pulse.
- Sits in the datapath between the control unit and the comparator. The comparator itself is unchanged.

Parameters:
- WIDTH, 16, operand width; matches the comparator A/B width.
- CMP_LAT, 1, clock edges spent in CMP before R is sampled; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request; level, held until done0 is seen.
- op0  input  1  requester 0 operation: 0 = equal (cmpeq), 1 = not-equal (cmpne).
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1, op1, a1, b1  input  1/1/WIDTH/WIDTH  requester 1; same meaning as port 0.
- grant0, grant1  output  1  high while that requester's op is in CMP or DONE.
- done0, done1  output  1  one-cycle pulse; the matching res is valid that cycle.
- res0, res1  output  1  last sampled R for that requester; held until that requester's next done.
- busy  output  1  high whenever state != IDLE.
- cmp_A, cmp_B  output  WIDTH  drive comparator A and B.
- cmp_eq, cmp_ne  output  1  drive comparator cmpeq and cmpne; at most one is high.
- cmp_R  input  1  comparator result R.

Behaviour:
- All outputs are registered. No combinational path exists from any req/op/a/b input to any output.
- Reset, asynchronous:
  - state=IDLE, rr_ptr=0 (requester 0 favoured).
  - All outputs 0, including cmp_A/cmp_B/cmp_eq/cmp_ne, res0/res1, done, grant and busy.
  - Counter cleared.
- The FSM has three states: IDLE, CMP, DONE.
- IDLE:
  - No req: stay in IDLE; cmp_eq=cmp_ne=0, cmp_A/cmp_B hold their last values.
  - Exactly one req: grant that requester.
  - Both reqs: grant the requester that rr_ptr points to.
  - On grant, at the same edge:
    - latch a/b into cmp_A/cmp_B;
    - set cmp_eq=~op and cmp_ne=op;
    - set grant_n=1, cnt=0 and go to CMP.
  - Changes to the requester's inputs after the grant edge have no effect on the op in flight.
- CMP:
  - cnt increments each edge.
  - At the edge where cnt==CMP_LAT-1:
    - res_n<=cmp_R and done_n<=1;
    - cmp_eq, cmp_ne <= 0;
    - rr_ptr <= the other requester;
    - go to DONE.
- DONE:
  - Lasts one cycle. done_n is high and grant_n stays high.
  - At the next edge: done_n<=0, grant_n<=0, go to IDLE.
- Requester handshake: the requester samples done_n at the DONE->IDLE edge and must drop req at that edge. The arbiter first samples req again one edge later, in IDLE.
- Latency and throughput:
  - Request seen at edge k -> done high from edge k+CMP_LAT to edge k+CMP_LAT+1.
  - Each op occupies CMP_LAT+2 cycles.
- A req still high in IDLE after its done is a new request. Round-robin still applies: if both reqs are high, the requester not just served wins.
- A req dropped before its grant is simply not served. There is no error flag.
- Reset asserted in CMP or DONE:
  - Immediately returns to reset values.
  - No done is generated and res is cleared.
  - Requesters re-issue after reset.
- done0 and done1 are never high together. grant0 and grant1 are never high together.

Test Plan:
- Reset, then req0=1, op0=0, a0=b0=16'h1234 -> grant0 at edge 1, cmp_eq=1, cmp_A=cmp_B=16'h1234; done0 pulses one cycle with res0=1; busy is low again 3 cycles after the request (CMP_LAT=1).
- req1=1, op1=1, a1=16'h0005, b1=16'h0006 -> cmp_ne=1, cmp_eq=0; done1 with res1=1; res0 unchanged.
- req0 and req1 asserted in the same cycle straight after reset, both held -> served in the order 0,1,0,1. done pulses are CMP_LAT+2 cycles apart and never overlap.
- After grant0, change a0 from 16'hFFFF to 16'h0000 (b0=16'hFFFF, op0=0) -> cmp_A stays 16'hFFFF; res0=1.
- Reset pulsed during CMP with req0 pending -> all outputs 0 within the reset cycle; no done0; after release with req0 held, a fresh op starts and completes correctly.
- CMP_LAT=3 build, req0, op0=1, a0=b0=16'h0000 -> cmp_ne held high for exactly 3 cycles; done0 at request+3; res0=0.
